fp_encode_seq: RTL and testbench

//  Sequential, parametrised linear-to-floating-point encoder: two's-complement sample -> sign, exponent, significand.
//  One shift per cycle normalisation FSM, optional round-half-up with carry renormalisation and saturation.

---
 rtl/fp_encode_seq.sv | 138 +++++++++++++
 tb/tb_fp_encode_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_encode_seq.sv
// Sequential linear-to-float encoder: two's-complement sample -> sign/exponent/significand, one normalising shift per cycle.
// Optional rounding (half-up, carry renormalise, saturate) enabled by defining FP_ENCODE_ROUND_EN.
module fp_encode_seq #(
    parameter int unsigned SIG_W = 4,
    parameter int unsigned EXP_W = 3,
    parameter int unsigned IN_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [EXP_W-1:0] exponent,
    output logic [SIG_W-1:0] significand,
    output logic             ovf
);
    localparam int unsigned EMAX  = (1 << EXP_W) - 1;
    localparam int unsigned MAG_W = IN_W - 1;

    if (IN_W != SIG_W + (1 << EXP_W)) begin : g_param_err
        $error("fp_encode_seq: IN_W must equal SIG_W + 2**EXP_W");
    end

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t             state;
    logic [MAG_W-1:0]   mag;
    logic [EXP_W-1:0]   exp_q;
    logic               sign_q;
    logic               ovf_q;

    logic               min_neg;
    logic [MAG_W-1:0]   mag_in;
    logic [SIG_W-1:0]   window;
    logic               norm_done;

    // Magnitude of the incoming sample; the most-negative value has no positive twin, so clamp it.
    always_comb begin
        min_neg = din[IN_W-1] && (din[IN_W-2:0] == '0);
        mag_in  = din[IN_W-1] ? MAG_W'(~din[MAG_W-1:0]) + MAG_W'(1) : din[MAG_W-1:0];
        if (min_neg) begin
            mag_in = '1;
        end
    end

    assign window    = mag[MAG_W-1 -: SIG_W];
    assign norm_done = mag[MAG_W-1] || (exp_q == '0);

`ifdef FP_ENCODE_ROUND_EN
    logic rbit;
    assign rbit = mag[MAG_W-1-SIG_W];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            sign        <= 1'b0;
            exponent    <= '0;
            significand <= '0;
            ovf         <= 1'b0;
            mag         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_q   <= din[IN_W-1];
                        mag      <= mag_in;
                        ovf_q    <= min_neg;
                        exp_q    <= EXP_W'(EMAX);
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        mag   <= {mag[MAG_W-2:0], 1'b0};
                        exp_q <= exp_q - EXP_W'(1);
                    end else begin
`ifdef FP_ENCODE_ROUND_EN
                        state <= ROUND;
`else
                        sign        <= sign_q;
                        exponent    <= exp_q;
                        significand <= window;
                        ovf         <= ovf_q;
                        out_valid   <= 1'b1;
                        state       <= OUT;
`endif
                    end
                end
`ifdef FP_ENCODE_ROUND_EN
                ROUND: begin
                    sign      <= sign_q;
                    out_valid <= 1'b1;
                    state     <= OUT;
                    if (!rbit) begin
                        significand <= window;
                        exponent    <= exp_q;
                        ovf         <= ovf_q;
                    end else if (window != '1) begin
                        significand <= window + SIG_W'(1);
                        exponent    <= exp_q;
                        ovf         <= ovf_q;
                    end else if (exp_q != EXP_W'(EMAX)) begin
                        // Round carried out of the window: renormalise to 1000.. and bump the exponent.
                        significand <= {1'b1, {(SIG_W-1){1'b0}}};
                        exponent    <= exp_q + EXP_W'(1);
                        ovf         <= ovf_q;
                    end else begin
                        significand <= '1;
                        exponent    <= exp_q;
                        ovf         <= 1'b1;
                    end
                end
`endif
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_encode_seq.sv
// Self-checking bench for fp_encode_seq: directed and random samples through a scoreboard queue.
module tb_fp_encode_seq;
    localparam int unsigned SIG_W = 4;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned IN_W  = 12;
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam int SIGMAX = (1 << SIG_W) - 1;
    localparam int MAXMAG = (1 << (IN_W - 1)) - 1;
`ifdef FP_ENCODE_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  din = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [SIG_W-1:0] significand;
    logic             ovf;

    typedef struct {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [SIG_W-1:0] sig;
        logic             ovf;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    fp_encode_seq #(.SIG_W(SIG_W), .EXP_W(EXP_W), .IN_W(IN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exponent(exponent),
        .significand(significand), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Value model: pick the smallest exponent whose shifted magnitude fits the significand.
    function automatic exp_t model(input logic [IN_W-1:0] d);
        exp_t r;
        int v, m, e, s;
        bit mn;
        v  = int'($signed(d));
        mn = (v == -(MAXMAG + 1));
        m  = (v < 0) ? -v : v;
        if (m > MAXMAG) m = MAXMAG;
        e = 0;
        while ((m >> e) > SIGMAX) e++;
        s = m >> e;
        r.ovf = mn;
        r.lat = ROUND_EN ? (EMAX - e) + 2 : (EMAX - e) + 1;
        if (ROUND_EN && e > 0 && (((m >> (e - 1)) & 1) == 1)) begin
            s++;
            if (s > SIGMAX) begin
                if (e < EMAX) begin
                    s = s >> 1;
                    e++;
                end else begin
                    s = SIGMAX;
                    r.ovf = 1'b1;
                end
            end
        end
        r.sign     = d[IN_W-1];
        r.exponent = EXP_W'(e);
        r.sig      = SIG_W'(s);
        return r;
    endfunction

    task automatic send(input logic [IN_W-1:0] d);
        int n;
        sb.push_back(model(d));
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        din      = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit check_lat);
        exp_t e;
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (check_lat) chk("latency", 32'(n), 32'(e.lat));
            chk("sign", 32'(sign), 32'(e.sign));
            chk("exponent", 32'(exponent), 32'(e.exponent));
            chk("significand", 32'(significand), 32'(e.sig));
            chk("ovf", 32'(ovf), 32'(e.ovf));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_out", 32'(in_ready), 32'd1);
        chk("out_valid_after_out", 32'(out_valid), 32'd0);
    endtask

    initial begin
        exp_t hold_e;
        logic [IN_W-1:0] d;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_fields", {28'd0, sign, exponent}, 32'd0);
        chk("reset_sig_ovf", {27'd0, significand, ovf}, 32'd0);

        // Directed values: plain case, carry renormalise, both saturation ends, small negative, zero.
        send(12'd422);  collect(1'b1);
        chk("t1_exp", 32'(exponent), 32'd5);
        chk("t1_sig", 32'(significand), 32'hD);
        send(12'd1000); collect(1'b1);
        chk("t2_exp", 32'(exponent), ROUND_EN ? 32'd7 : 32'd6);
        chk("t2_sig", 32'(significand), ROUND_EN ? 32'h8 : 32'hF);
        send(12'h7FF);  collect(1'b1);
        send(12'h800);  collect(1'b1);
        chk("t3_minneg_ovf", 32'(ovf), 32'd1);
        send(12'hFFD);  collect(1'b1);
        send(12'h000);  collect(1'b1);
        send(12'd16);   collect(1'b1);
        send(12'd15);   collect(1'b1);
        send(12'hFF0);  collect(1'b1);

        // Back-pressure: outputs hold, busy input ignored.
        send(12'd422);
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        hold_e = sb[0];
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sig", {28'd0, significand}, 32'(hold_e.sig));
            chk("hold_exp", 32'(exponent), 32'(hold_e.exponent));
            if (i == 2) begin
                din = 12'h123;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        collect(1'b0);
        repeat (12) @(negedge clk);
        chk("ignored_no_output", 32'(out_valid), 32'd0);
        chk("ignored_in_ready", 32'(in_ready), 32'd1);

        // Reset during NORM discards the sample.
        send(12'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_fields", {24'd0, sign, exponent, significand, ovf}, 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        send(12'd422);  collect(1'b1);

        for (int i = 0; i < 10; i++) begin
            d = IN_W'($urandom);
            send(d);
            collect(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
